// File: rtl/vga_stream_adapter_if.sv
// Purpose : Avalon-ST beat bundle (data, SOP/EOP, valid/ready) shared by the pixel
//           producer side and the VGA core side of vga_stream_adapter.
// Latency : none; this is a wire bundle.
// Backpr. : ready flows from slave to master; a beat moves on valid && ready.
// Ports   : W-bit data, startofpacket, endofpacket, valid (master->slave), ready (slave->master).
interface vga_stream_adapter_if #(
  parameter int W = 8
) ();
  logic [W-1:0] data;
  logic         startofpacket;
  logic         endofpacket;
  logic         valid;
  logic         ready;

  modport master (output data, startofpacket, endofpacket, valid, input ready);
  modport slave  (input data, startofpacket, endofpacket, valid, output ready);
endinterface

// File: rtl/vga_stream_adapter.sv
// Purpose : grayscale-to-RGB stream adapter with per-frame colour mode and regenerated framing.
// Latency : 1 cycle from input accept to output valid (2-entry skid buffer).
// Backpr. : pix_if.ready is low only while the skid register is full; nothing is lost or duplicated.
// Ports   : clk_i, rst_ni (async, active low); mode_i, threshold_i (latched at SOP);
//           err_clear_i; pix_if (slave, PIXEL_W gray in); vga_if (master, {R,G,B} out);
//           frame_err_o (sticky framing error); frame_done_o (output EOP beat accepted).
module vga_stream_adapter #(
  parameter int PIXEL_W  = 8,
  parameter int OUT_CH_W = 10,
  parameter int FRAME_W  = 640,
  parameter int FRAME_H  = 480
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [1:0]           mode_i,
  input  logic [PIXEL_W-1:0]   threshold_i,
  input  logic                 err_clear_i,
  vga_stream_adapter_if.slave  pix_if,
  vga_stream_adapter_if.master vga_if,
  output logic                 frame_err_o,
  output logic                 frame_done_o
);
  localparam int N     = FRAME_W * FRAME_H;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;  // count only spans 0..N-1
  localparam int DW    = 3 * OUT_CH_W;

  typedef struct packed {
    logic [DW-1:0] dat;
    logic          sop;
    logic          eop;
  } beat_t;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         mode_q, mode_d;
  logic [PIXEL_W-1:0] thr_q, thr_d;
  logic               err_q, err_d;
  beat_t              m_q, m_d, s_q, s_d;
  logic               m_vld_q, m_vld_d, s_vld_q, s_vld_d;

  logic               acc, start, pop, push, emit, err_set, nb_sop, nb_eop;
  logic [1:0]         mode_eff;
  logic [PIXEL_W-1:0] thr_eff, p, s, r8, g8, b8;
  logic               h;
  beat_t              nb;

  // MSB replication: output bit i (from the top) copies input bit (i mod PIXEL_W) from the top.
  function automatic logic [OUT_CH_W-1:0] widen(input logic [PIXEL_W-1:0] c);
    logic [OUT_CH_W-1:0] w;
    for (int i = 0; i < OUT_CH_W; i++) begin
      w[OUT_CH_W-1-i] = c[PIXEL_W-1-(i % PIXEL_W)];
    end
    return w;
  endfunction

  assign acc      = pix_if.valid && !s_vld_q;
  assign start    = acc && pix_if.startofpacket;
  assign pop      = m_vld_q && vga_if.ready;
  assign push     = acc && emit;
  // The SOP beat itself already uses the mode being latched for its frame.
  assign mode_eff = start ? mode_i : mode_q;
  assign thr_eff  = start ? threshold_i : thr_q;

  always_comb begin
    p  = pix_if.data;
    h  = p[PIXEL_W-1];
    s  = {p[PIXEL_W-2:0], 1'b0};
    r8 = '0;
    g8 = '0;
    b8 = '0;
    case (mode_eff)
      2'd0: begin r8 = p;  g8 = p;  b8 = p;  end
      2'd1: begin r8 = ~p; g8 = ~p; b8 = ~p; end
      2'd2: begin
        r8 = (p >= thr_eff) ? '1 : '0;
        g8 = r8;
        b8 = r8;
      end
      default: begin
        r8 = h ? '1 : s;
        g8 = h ? s : '0;
        b8 = h ? '0 : ~s;
      end
    endcase
  end

  // Framing FSM: output SOP/EOP come only from the pixel counter; input flags are checked only.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    thr_d   = thr_q;
    emit    = 1'b0;
    err_set = 1'b0;
    nb_sop  = 1'b0;
    nb_eop  = 1'b0;
    if (acc) begin
      if (pix_if.startofpacket) begin
        emit   = 1'b1;
        nb_sop = 1'b1;
        mode_d = mode_i;
        thr_d  = threshold_i;
        if (state_q == ACTIVE) err_set = 1'b1;  // previous frame truncated
        if (N == 1) begin
          nb_eop  = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
          if (!pix_if.endofpacket) err_set = 1'b1;
        end else begin
          state_d = ACTIVE;
          cnt_d   = CNT_W'(1);
          if (pix_if.endofpacket) err_set = 1'b1;
        end
      end else if (state_q == ACTIVE) begin
        emit = 1'b1;
        if (cnt_q == CNT_W'(N-1)) begin
          nb_eop  = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
          if (!pix_if.endofpacket) err_set = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (pix_if.endofpacket) err_set = 1'b1;
        end
      end
      // Beats without SOP in IDLE are accepted and dropped.
    end
    err_d = err_set ? 1'b1 : (err_clear_i ? 1'b0 : err_q);
  end

  // Skid buffer: M feeds the output, S only fills while M is stalled.
  always_comb begin
    nb      = '{dat: {widen(r8), widen(g8), widen(b8)}, sop: nb_sop, eop: nb_eop};
    m_d     = m_q;
    s_d     = s_q;
    m_vld_d = m_vld_q;
    s_vld_d = s_vld_q;
    if (!m_vld_q || pop) begin
      if (s_vld_q) begin
        // No push possible here: input ready is low while S is full.
        m_d     = s_q;
        m_vld_d = 1'b1;
        s_vld_d = 1'b0;
      end else begin
        m_d     = push ? nb : '0;
        m_vld_d = push;
      end
    end else if (push) begin
      s_d     = nb;
      s_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= '0;
      thr_q   <= '0;
      err_q   <= 1'b0;
      m_q     <= '0;
      s_q     <= '0;
      m_vld_q <= 1'b0;
      s_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      thr_q   <= thr_d;
      err_q   <= err_d;
      m_q     <= m_d;
      s_q     <= s_d;
      m_vld_q <= m_vld_d;
      s_vld_q <= s_vld_d;
    end
  end

  assign pix_if.ready         = !s_vld_q;
  assign vga_if.data          = m_q.dat;
  assign vga_if.startofpacket = m_q.sop;
  assign vga_if.endofpacket   = m_q.eop;
  assign vga_if.valid         = m_vld_q;
  assign frame_err_o          = err_q;
  assign frame_done_o         = pop && m_q.eop;
endmodule

// File: tb/tb_vga_stream_adapter.sv
// Purpose : self-checking bench for vga_stream_adapter (N = 4x2 = 8 pixels per frame).
// Latency : expected beats are queued at input accept and matched when the output transfers.
// Backpr. : output ready is held high, held low or randomised per phase.
module tb_vga_stream_adapter;
  localparam int DW = 30;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          sop;
    logic          eop;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] mode;
  logic [7:0] thr;
  logic err_clear;
  logic frame_err, frame_done;
  int   total = 0;
  int   bad = 0;
  int   rdy_cfg = 0;
  exp_t q[$];
  exp_t e;
  logic prev_stall = 1'b0;
  logic [DW+1:0] prev_out;

  logic [7:0] t1p [8] = '{8'h00, 8'h80, 8'hFF, 8'h40, 8'h12, 8'h34, 8'hAB, 8'hFF};
  logic [9:0] t1c [8] = '{10'h000, 10'h202, 10'h3FF, 10'h101, 10'h048, 10'h0D0, 10'h2AE, 10'h3FF};
  logic [7:0] t3p [4] = '{8'h40, 8'hC0, 8'h00, 8'hFF};
  logic [29:0] t3e [4] = '{{10'h202, 10'h000, 10'h1FD}, {10'h3FF, 10'h202, 10'h000},
                           {10'h000, 10'h000, 10'h3FF}, {10'h3FF, 10'h3FB, 10'h000}};
  logic [7:0] t4p [4] = '{8'h7F, 8'h80, 8'h00, 8'hFF};
  logic [9:0] t4c [4] = '{10'h000, 10'h3FF, 10'h000, 10'h3FF};
  logic [7:0] t4q [4] = '{8'h00, 8'hFF, 8'h80, 8'h40};
  logic [9:0] t4d [4] = '{10'h3FF, 10'h000, 10'h1FD, 10'h2FE};

  always #5 clk = ~clk;

  vga_stream_adapter_if #(.W(8))  pix_if ();
  vga_stream_adapter_if #(.W(DW)) vga_if ();

  vga_stream_adapter #(
    .PIXEL_W(8), .OUT_CH_W(10), .FRAME_W(4), .FRAME_H(2)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .mode_i(mode), .threshold_i(thr),
    .err_clear_i(err_clear), .pix_if(pix_if), .vga_if(vga_if),
    .frame_err_o(frame_err), .frame_done_o(frame_done)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic logic [29:0] ch3(input logic [9:0] c);
    return {c, c, c};
  endfunction

  function automatic logic [29:0] gray3(input logic [7:0] p);
    logic [9:0] c;
    c = {p, p[7:6]};
    return {c, c, c};
  endfunction

  // Drives one beat, waits (bounded) for input ready, queues the expectation if it should emerge.
  task automatic send(input logic [7:0] p, input logic sop, input logic eop, input logic emit,
                      input logic [29:0] ed, input logic esop, input logic eeop, input logic chk_lat);
    int n;
    exp_t x;
    @(negedge clk);
    pix_if.data          = p;
    pix_if.startofpacket = sop;
    pix_if.endofpacket   = eop;
    pix_if.valid         = 1'b1;
    n = 0;
    while (!pix_if.ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!pix_if.ready) begin
      bad++;
      $display("FAIL in_ready_timeout: ready_out still 0 after %0d cycles, want 1", n);
      pix_if.valid = 1'b0;
      return;
    end
    if (emit) begin
      x.d = ed; x.sop = esop; x.eop = eeop;
      q.push_back(x);
    end
    @(posedge clk);
    #1;
    pix_if.valid = 1'b0;
    if (chk_lat) check("latency_valid", vga_if.valid, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: %0d beats outstanding, want 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    vga_if.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_cfg)
        0:       vga_if.ready = 1'b1;
        1:       vga_if.ready = 1'($urandom_range(0, 1));
        default: vga_if.ready = 1'b0;
      endcase
    end
  end

  // Monitor: compares every output transfer against the head of the scoreboard queue.
  always @(negedge clk) begin
    if (vga_if.valid && vga_if.ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got data %0h with none expected", vga_if.data);
      end else begin
        e = q.pop_front();
        check("out_data", vga_if.data, e.d);
        check("out_sop", vga_if.startofpacket, e.sop);
        check("out_eop", vga_if.endofpacket, e.eop);
        check("frame_done", frame_done, e.eop);
      end
    end else if (frame_done) begin
      check("frame_done_idle", frame_done, 0);
    end
    if (prev_stall && rst_n)
      check("stall_stable", {vga_if.data, vga_if.startofpacket, vga_if.endofpacket}, prev_out);
    if (rst_n && !pix_if.ready) check("skid_full_implies_valid", vga_if.valid, 1);
    prev_stall = rst_n && vga_if.valid && !vga_if.ready;
    prev_out   = {vga_if.data, vga_if.startofpacket, vga_if.endofpacket};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, test incomplete");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    mode = 2'd0; thr = 8'h00; err_clear = 1'b0;
    pix_if.valid = 1'b0; pix_if.data = '0;
    pix_if.startofpacket = 1'b0; pix_if.endofpacket = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", vga_if.valid, 0);
    check("rst_ready_out", pix_if.ready, 1);
    check("rst_frame_err", frame_err, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_outputs", {vga_if.data, vga_if.startofpacket, vga_if.endofpacket}, 0);
    rst_n = 1'b1;

    // T1: gray mode, one beat per cycle, latency and framing.
    for (int i = 0; i < 8; i++)
      send(t1p[i], i == 0, i == 7, 1, ch3(t1c[i]), i == 0, i == 7, 1);
    drain();
    check("t1_frame_err", frame_err, 0);

    // T3: heat mode; mode_i changed after SOP must not take effect.
    mode = 2'd3;
    for (int i = 0; i < 8; i++) begin
      send(t3p[i%4], i == 0, i == 7, 1, t3e[i%4], i == 0, i == 7, 0);
      mode = 2'd0;
    end
    drain();

    // T4: threshold mode (threshold change mid-frame ignored), then invert mode.
    mode = 2'd2; thr = 8'h80;
    for (int i = 0; i < 8; i++) begin
      send(t4p[i%4], i == 0, i == 7, 1, ch3(t4c[i%4]), i == 0, i == 7, 0);
      thr = 8'h00;
    end
    mode = 2'd1;
    for (int i = 0; i < 8; i++)
      send(t4q[i%4], i == 0, i == 7, 1, ch3(t4d[i%4]), i == 0, i == 7, 0);
    drain();
    check("t4_frame_err", frame_err, 0);

    // T2: random output backpressure over three frames.
    mode = 2'd0;
    rdy_cfg = 1;
    for (int f = 0; f < 3; f++) begin
      for (int j = 0; j < 8; j++) begin
        logic [7:0] p;
        p = 8'($urandom_range(0, 255));
        send(p, j == 0, j == 7, 1, gray3(p), j == 0, j == 7, 0);
      end
    end
    drain();
    rdy_cfg = 0;
    check("t2_frame_err", frame_err, 0);

    // T5: stray beats dropped; early input EOP and missing final EOP flag an error.
    send(8'h11, 0, 0, 0, '0, 0, 0, 0);
    send(8'h22, 0, 1, 0, '0, 0, 0, 0);
    send(8'h33, 0, 0, 0, '0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      send(t1p[i], i == 0, i == 4, 1, ch3(t1c[i]), i == 0, i == 7, 0);
    drain();
    repeat (4) @(negedge clk);
    check("t5_err_set", frame_err, 1);
    repeat (4) @(negedge clk);
    check("t5_err_sticky", frame_err, 1);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    check("t5_err_cleared", frame_err, 0);

    // T6: SOP on pixel 4 restarts the frame, then reset mid-frame flushes a stalled beat.
    for (int i = 0; i < 6; i++)
      send(t1p[i], i == 0 || i == 3, 0, 1, ch3(t1c[i]), i == 0 || i == 3, 0, 0);
    drain();
    check("t6_err_sop_restart", frame_err, 1);
    rdy_cfg = 2;
    repeat (2) @(negedge clk);
    send(8'h55, 1, 0, 0, '0, 0, 0, 0);
    check("t6_stalled_valid", vga_if.valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", vga_if.valid, 0);
    check("t6_rst_ready_out", pix_if.ready, 1);
    check("t6_rst_frame_err", frame_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rdy_cfg = 0;
    for (int i = 0; i < 8; i++)
      send(t1p[i], i == 0, i == 7, 1, ch3(t1c[i]), i == 0, i == 7, 0);
    drain();
    check("t6_clean_frame_err", frame_err, 0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
